mm_rr_arbiter: RTL and testbench
================================

Name: mm_rr_arbiter

Overview:
- Shares one BRAM-like memory port (a/d/rd/we/spo/ready) between NREQ requesters, each of which uses the same BRAM-like protocol.
- Requesters are typically the AXI-Lite bridge, a DMA engine and debug logic. The single downstream port feeds a peripheral such as the uart16550 register file.
- Latches one-cycle request pulses per port and grants round-robin. Issues one downstream op at a time and routes completion and read data back to the originating requester.

Parameters:
- NREQ, 2, number of requester ports (legal range 2..8).
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with MM_ARB_TIMEOUT_EN.

Ports:
- s_axi_clk  in  1  single clock.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- req_a  in  NREQ*32  per-port address; port i occupies bits [32i+31:32i].
- req_d  in  NREQ*32  per-port write data, same packing as req_a.
- req_rd  in  NREQ  one-cycle read request pulse.
- req_we  in  NREQ  one-cycle write request pulse.
- req_spo  out  32  read data; valid with req_ready, held until the next completion.
- req_ready  out  NREQ  one-cycle completion pulse per port.
- a  out  32  downstream address.
- d  out  32  downstream write data.
- rd  out  1  downstream read pulse.
- we  out  1  downstream write pulse.
- spo  in  32  downstream read data.
- ready  in  1  downstream completion.
- grant_id  out  clog2(NREQ)  port currently owning the downstream.
- busy  out  1  high while the FSM is in WAIT.
- err_overflow  out  NREQ  sticky; a request arrived while that port already had an op pending.
- err_timeout  out  1  sticky watchdog flag (0 when the feature is compiled out).

Behaviour:
- Reset (async assert, sync deassert by user):
  - all outputs 0; a/d/req_spo = 0.
  - pending[] = 0; round-robin pointer = 0; FSM = IDLE.
  - A reset mid-operation drops outstanding ops silently. rd/we fall immediately.
- Capture:
  - A pulse on req_rd[i] or req_we[i] at edge T sets pending[i] and latches addr, data and type.
  - we wins if rd and we pulse together; the op is recorded as a write.
- Overflow:
  - A new pulse while pending[i] is already set is dropped and sets err_overflow[i].
  - Exception: a new pulse on the same edge that port i completes is accepted; pending[i] stays set with the new op, and no error is raised.
- FSM IDLE:
  - If any pending bit is set, pick the first set bit searching from the pointer upward with wrap.
  - Register a/d and drive rd or we high for exactly one cycle; set grant_id.
  - Pointer = winner+1 mod NREQ. Go to WAIT.
- FSM WAIT:
  - rd and we are 0.
  - ready is sampled from the first edge after the pulse edge onward.
  - On ready=1: capture spo into req_spo (reads only; writes leave req_spo unchanged). Pulse req_ready[grant_id] for one cycle, clear pending[grant_id], return to IDLE.
- Latency:
  - With ready tied high: request at edge T, downstream pulse visible after edge T+1, req_ready visible after edge T+2.
  - Back-to-back grants are separated by at least one IDLE cycle.
- Fairness: with all ports pending, grants cycle 0,1,..,NREQ-1,0,...; no port waits more than NREQ ops.
- Only one downstream op is ever outstanding; a/d hold their value through WAIT.

Optional Feature:
- Macro: MM_ARB_TIMEOUT_EN.
- With the macro: a counter runs in WAIT. If ready is not seen within TIMEOUT_CYCLES cycles, the arbiter force-completes:
  - req_ready pulse to the owning port; req_spo = 32'hDEAD_BEEF for reads.
  - err_timeout set (sticky); FSM returns to IDLE.
- Without the macro: WAIT lasts indefinitely, no counter is built, and err_timeout is tied to 0.

Decomposition:
- Package mm_arb_pkg holds:
  - FSM state encoding (IDLE, WAIT);
  - the poison constant 32'hDEAD_BEEF;
  - the op-type encoding (READ, WRITE).
- Sub-module rr_pick: combinational round-robin priority encoder. Inputs: request vector and pointer. Outputs: grant index and valid.

Test Plan:
- Single read on port 0 to a=0x10, ready tied high, spo=0x12345678 -> rd pulse with a=0x10 after edge T+1; req_ready[0] after edge T+2; req_spo=0x12345678.
- Ports 0 and 1 pulse writes on the same edge (d=0xA, 0xB), pointer=0 -> port 0 is written first, then port 1; we pulses carry d=0xA then d=0xB; pointer ends at 0.
- All ports request continuously for 3*NREQ ops -> grant_id sequence is strictly cyclic; each port gets exactly 3 req_ready pulses.
- Port 1 pulses twice while its first op is pending and ready is held low 5 cycles -> err_overflow[1]=1; exactly one req_ready[1].
- Port 0 completes on the same edge it issues a new read -> no err_overflow; the second op is issued next.
- MM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16, ready stuck 0 on a read -> req_ready after 16 WAIT cycles; req_spo=0xDEADBEEF; err_timeout=1. Assert reset mid-WAIT -> rd/we/busy drop to 0 asynchronously.

Source files
------------

// File: rtl/mm_arb_pkg.sv
// Shared types and constants for the memory-port round-robin arbiter.
package mm_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Read data returned when the watchdog has to force-complete an op
  localparam logic [31:0] POISON = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic [GW-1:0]   idx,
  output logic            valid
);

  int pos;

  // Walk from the farthest candidate back to ptr so the nearest hit overwrites.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = (int'(ptr) + k) % NREQ;
      if (req[pos]) begin
        idx   = GW'(pos);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mm_rr_arbiter.sv
// Round-robin arbiter sharing one BRAM-like port among NREQ requesters.
// Optional watchdog compiled in with MM_ARB_TIMEOUT_EN.
module mm_rr_arbiter
  import mm_arb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    s_axi_clk,
  input  logic                    s_axi_aresetn,
  input  logic [NREQ*32-1:0]      req_a,
  input  logic [NREQ*32-1:0]      req_d,
  input  logic [NREQ-1:0]         req_rd,
  input  logic [NREQ-1:0]         req_we,
  output logic [31:0]             req_spo,
  output logic [NREQ-1:0]         req_ready,
  output logic [31:0]             a,
  output logic [31:0]             d,
  output logic                    rd,
  output logic                    we,
  input  logic [31:0]             spo,
  input  logic                    ready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic [NREQ-1:0]         err_overflow,
  output logic                    err_timeout
);

  // Handshake: requesters pulse rd/we for one cycle and get a one-cycle req_ready
  // when done; downstream gets a one-cycle rd/we and answers with ready (>=1 cycle later).
  localparam int GW = $clog2(NREQ);

  state_t          state, state_d;
  logic [NREQ-1:0] pending;
  logic [31:0]     addr_q [NREQ];
  logic [31:0]     data_q [NREQ];
  op_t             op_q   [NREQ];
  logic [GW-1:0]   ptr;
  logic [GW-1:0]   pick_idx;
  logic            pick_valid;
  logic            issue;
  logic            complete;
  logic            timed_out;
  logic            cur_read;
  logic [NREQ-1:0] new_req;
  logic [NREQ-1:0] done_vec;

  assign new_req  = req_rd | req_we;
  assign done_vec = complete ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_id) : '0;
  assign busy     = (state == ST_WAIT);

  rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
    .req   (pending),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef MM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (issue)
        tmo_cnt <= '0;
      else if (state == ST_WAIT)
        tmo_cnt <= tmo_cnt + TW'(1);
      if (timed_out)
        err_timeout <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)
      state <= ST_IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d   = state;
    issue     = 1'b0;
    complete  = 1'b0;
    timed_out = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          issue   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ready)
          complete = 1'b1;
`ifdef MM_ARB_TIMEOUT_EN
        else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          complete  = 1'b1;
          timed_out = 1'b1;
        end
`endif
        if (complete)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pulse landing on the completion edge of its own port refills the slot cleanly.
  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      pending      <= '0;
      err_overflow <= '0;
      for (int i = 0; i < NREQ; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        op_q[i]   <= OP_READ;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (new_req[i]) begin
          if (!pending[i] || done_vec[i]) begin
            pending[i] <= 1'b1;
            addr_q[i]  <= req_a[32*i +: 32];
            data_q[i]  <= req_d[32*i +: 32];
            op_q[i]    <= req_we[i] ? OP_WRITE : OP_READ;
          end else begin
            err_overflow[i] <= 1'b1;
          end
        end else if (done_vec[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      a         <= '0;
      d         <= '0;
      rd        <= 1'b0;
      we        <= 1'b0;
      grant_id  <= '0;
      ptr       <= '0;
      cur_read  <= 1'b0;
      req_ready <= '0;
      req_spo   <= '0;
    end else begin
      rd        <= 1'b0;
      we        <= 1'b0;
      req_ready <= '0;
      if (issue) begin
        a        <= addr_q[pick_idx];
        d        <= data_q[pick_idx];
        rd       <= (op_q[pick_idx] == OP_READ);
        we       <= (op_q[pick_idx] == OP_WRITE);
        cur_read <= (op_q[pick_idx] == OP_READ);
        grant_id <= pick_idx;
        ptr      <= (pick_idx == GW'(NREQ - 1)) ? '0 : pick_idx + GW'(1);
      end
      if (complete) begin
        req_ready <= done_vec;
        if (cur_read)
          req_spo <= timed_out ? POISON : spo;
      end
    end
  end

endmodule

// File: tb/tb_mm_rr_arbiter.sv
// Scoreboard bench for mm_rr_arbiter: spec-level reference model predicts grants and completions.
module tb_mm_rr_arbiter;

  localparam int NREQ           = 3;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int GW             = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ*32-1:0]  req_a = '0;
  logic [NREQ*32-1:0]  req_d = '0;
  logic [NREQ-1:0]     req_rd = '0;
  logic [NREQ-1:0]     req_we = '0;
  logic [31:0]         req_spo;
  logic [NREQ-1:0]     req_ready;
  logic [31:0]         a, d;
  logic                rd, we;
  logic [31:0]         spo = '0;
  logic                ready = 1'b0;
  logic [GW-1:0]       grant_id;
  logic                busy;
  logic [NREQ-1:0]     err_overflow;
  logic                err_timeout;

  mm_rr_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .s_axi_clk     (clk),
    .s_axi_aresetn (rst_n),
    .req_a         (req_a),
    .req_d         (req_d),
    .req_rd        (req_rd),
    .req_we        (req_we),
    .req_spo       (req_spo),
    .req_ready     (req_ready),
    .a             (a),
    .d             (d),
    .rd            (rd),
    .we            (we),
    .spo           (spo),
    .ready         (ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .err_overflow  (err_overflow),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected downstream ops {port[8], is_write, addr[32], data[32]} and completions {port[8], rdata[32]}
  logic [72:0] exp_iss_q[$];
  logic [39:0] exp_done_q[$];

  // ---------------- reference model ----------------
  bit          m_pend [NREQ];
  bit          m_wr   [NREQ];
  logic [31:0] m_addr [NREQ];
  logic [31:0] m_data [NREQ];
  bit          m_ovf  [NREQ];
  int          m_ptr, m_owner, m_cnt, m_done_port, m_win;
  bit          m_wait, m_owner_wr, m_tmo, m_fin, m_fin_tmo;
  logic [31:0] m_spo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        m_pend[i] = 0; m_wr[i] = 0; m_addr[i] = 0; m_data[i] = 0; m_ovf[i] = 0;
      end
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_wait = 0; m_owner_wr = 0; m_tmo = 0; m_spo = '0;
      exp_iss_q.delete();
      exp_done_q.delete();
    end else begin
      m_done_port = -1;
      if (!m_wait) begin
        m_win = -1;
        for (int k = 0; k < NREQ; k++)
          if (m_win < 0 && m_pend[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
        if (m_win >= 0) begin
          exp_iss_q.push_back({8'(m_win), m_wr[m_win], m_addr[m_win], m_data[m_win]});
          m_ptr = (m_win + 1) % NREQ;
          m_wait = 1; m_owner = m_win; m_owner_wr = m_wr[m_win]; m_cnt = 0;
        end
      end else begin
        m_fin = ready; m_fin_tmo = 0;
`ifdef MM_ARB_TIMEOUT_EN
        if (!ready && m_cnt == TIMEOUT_CYCLES - 1) begin m_fin = 1; m_fin_tmo = 1; end
`endif
        if (m_fin) begin
          if (!m_owner_wr) m_spo = m_fin_tmo ? 32'hDEAD_BEEF : spo;
          if (m_fin_tmo) m_tmo = 1;
          exp_done_q.push_back({8'(m_owner), m_spo});
          m_wait = 0;
          m_done_port = m_owner;
        end else begin
          m_cnt++;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_rd[i] || req_we[i]) begin
          if (!m_pend[i] || m_done_port == i) begin
            m_pend[i] = 1; m_wr[i] = req_we[i];
            m_addr[i] = req_a[32*i +: 32]; m_data[i] = req_d[32*i +: 32];
          end else begin
            m_ovf[i] = 1;
          end
        end else if (m_done_port == i) begin
          m_pend[i] = 0;
        end
      end
    end
  end

  function automatic logic [NREQ-1:0] ovf_vec();
    for (int i = 0; i < NREQ; i++) ovf_vec[i] = m_ovf[i];
  endfunction

  function automatic bit model_idle();
    model_idle = !m_wait;
    for (int i = 0; i < NREQ; i++) if (m_pend[i]) model_idle = 0;
  endfunction

  // ---------------- monitor ----------------
  int          rdy_cnt [NREQ];
  bit          glog_en = 0;
  int          glog[$];
  logic [31:0] held_a, held_d;
  logic [72:0] iss_item;
  logic [39:0] done_item;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd || we) begin
        chk("issue_expected", exp_iss_q.size() != 0, 1);
        if (exp_iss_q.size() != 0) begin
          iss_item = exp_iss_q.pop_front();
          chk("grant_id", grant_id, iss_item[72:65]);
          chk("issue_we", we, iss_item[64]);
          chk("issue_rd", rd, !iss_item[64]);
          chk("issue_a", a, iss_item[63:32]);
          chk("issue_d", d, iss_item[31:0]);
          held_a = iss_item[63:32];
          held_d = iss_item[31:0];
        end
        if (glog_en) glog.push_back(int'(grant_id));
      end else if (busy) begin
        chk("a_held", a, held_a);
        chk("d_held", d, held_d);
      end
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) rdy_cnt[i]++;
        chk("done_expected", exp_done_q.size() != 0, 1);
        if (exp_done_q.size() != 0) begin
          done_item = exp_done_q.pop_front();
          chk("req_ready_port", req_ready, {{(NREQ-1){1'b0}}, 1'b1} << done_item[39:32]);
          chk("req_spo", req_spo, done_item[31:0]);
        end
      end
      chk("busy", busy, m_wait);
      chk("err_overflow", err_overflow, ovf_vec());
      chk("err_timeout", err_timeout, m_tmo);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input int p, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    req_a[32*p +: 32] = addr;
    req_d[32*p +: 32] = data;
    if (wr) req_we[p] = 1'b1;
    else    req_rd[p] = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    req_rd = '0;
    req_we = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!model_idle() && n < 300) begin
      step();
      n++;
    end
    chk("drain_in_time", n < 300, 1);
    repeat (2) step();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NREQ; i++) rdy_cnt[i] = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, bn;
    #12;
    chk("rst_rd", rd, 0);
    chk("rst_we", we, 0);
    chk("rst_a", a, 0);
    chk("rst_d", d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_req_spo", req_spo, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_err_overflow", err_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single read, ready tied high: rd after T+1, req_ready after T+2
    ready = 1'b1;
    spo   = 32'h1234_5678;
    pulse(0, 0, 32'h10, 32'h0);
    step();
    chk("lat_rd_not_yet", rd, 0);
    step();
    chk("lat_rd_at_t1", rd, 1);
    chk("lat_a_at_t1", a, 32'h10);
    step();
    chk("lat_ready_at_t2", req_ready, 1);
    chk("lat_spo_at_t2", req_spo, 32'h1234_5678);
    wait_idle();

    // Simultaneous writes on ports 0 and 1
    pulse(0, 1, 32'h20, 32'hA);
    pulse(1, 1, 32'h24, 32'hB);
    step();
    wait_idle();

    // Three rounds with every port requesting: grant sequence must be cyclic
    glog.delete();
    glog_en = 1;
    for (int r = 0; r < 3; r++) begin
      spo = $urandom;
      for (int p = 0; p < NREQ; p++) pulse(p, 0, 32'h100 + 32'(4 * p), 32'h0);
      step();
      wait_idle();
    end
    glog_en = 0;
    chk("cyclic_len", glog.size(), 3 * NREQ);
    for (int i = 1; i < glog.size(); i++) chk("cyclic_order", glog[i], (glog[i-1] + 1) % NREQ);
    for (int p = 0; p < NREQ; p++) begin
      n = 0;
      foreach (glog[i]) if (glog[i] == p) n++;
      chk("cyclic_per_port", n, 3);
    end

    // Overflow on port 1 while its op is stalled
    clear_counts();
    ready = 1'b0;
    pulse(1, 0, 32'h30, 32'h0);
    step();
    pulse(1, 1, 32'h34, 32'h1);
    step();
    pulse(1, 0, 32'h38, 32'h2);
    step();
    repeat (5) step();
    ready = 1'b1;
    spo   = 32'hCAFE_0001;
    wait_idle();
    chk("ovf_port1", err_overflow[1], 1);
    chk("ovf_one_ready", rdy_cnt[1], 1);

    // Port 0 issues a new read on its own completion edge
    clear_counts();
    ready = 1'b0;
    spo   = 32'h0000_5A5A;
    pulse(0, 0, 32'h40, 32'h0);
    step();
    n = 0;
    while (!busy && n < 20) begin step(); n++; end
    chk("same_edge_busy", busy, 1);
    ready = 1'b1;
    pulse(0, 0, 32'h44, 32'h0);
    step();
    wait_idle();
    chk("same_edge_no_ovf", err_overflow[0], 0);
    chk("same_edge_two_ready", rdy_cnt[0], 2);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      spo   = $urandom;
      for (int p = 0; p < NREQ; p++) begin
        if ($urandom_range(0, 5) == 0) begin
          req_a[32*p +: 32] = $urandom;
          req_d[32*p +: 32] = $urandom;
          req_rd[p] = $urandom_range(0, 1);
          req_we[p] = $urandom_range(0, 1);
        end
      end
      step();
    end
    ready = 1'b1;
    wait_idle();

`ifdef MM_ARB_TIMEOUT_EN
    // Stuck downstream: forced completion after TIMEOUT_CYCLES wait cycles
    ready = 1'b0;
    pulse(0, 0, 32'h80, 32'h0);
    step();
    n = 0; bn = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) bn++;
    end while (!req_ready[0] && n < 60);
    chk("tmo_ready_seen", req_ready[0], 1);
    chk("tmo_wait_cycles", bn, TIMEOUT_CYCLES);
    chk("tmo_spo", req_spo, 32'hDEAD_BEEF);
    chk("tmo_flag", err_timeout, 1);
    ready = 1'b1;
    wait_idle();
`else
    chk("timeout_off", err_timeout, 0);
`endif

    chk("iss_q_drained", exp_iss_q.size(), 0);
    chk("done_q_drained", exp_done_q.size(), 0);

    // Reset in the middle of an op drops rd/busy immediately
    ready = 1'b0;
    pulse(2, 0, 32'h90, 32'h0);
    step();
    @(negedge clk);
    chk("pre_reset_rd", rd, 1);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rd", rd, 0);
    chk("async_we", we, 0);
    chk("async_busy", busy, 0);
    chk("async_err_overflow", err_overflow, 0);
    chk("async_err_timeout", err_timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (3) step();
    chk("post_reset_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
